pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Program-counter sequencer for the microprocessor fetch stage. It owns the PC, runs and stops program execution, and resolves taken branches. It drives the 3-bit jump pointer into the jump lookup table and loads the 6-bit target that the table returns in the same cycle. It also reports completion, a fault flag and an execution cycle count to the top level and the testbench.

Parameters:
PC_W, 8, PC width in bits; PC wraps past 2^PC_W-1 only as a fault.
JW, 6, width of the jump-table target; zero-extended to PC_W on load.
NUM_TGT, 5, number of valid jump pointers (codes 0..NUM_TGT-1); higher codes are faults.
CYC_W, 16, width of the cycle counter.

Ports:
Clk  in  1  system clock; all state updates on the rising edge.
Reset  in  1  asynchronous, active-high reset.
Start  in  1  one-cycle pulse; begins or restarts execution at PC 0.
Stall  in  1  hold the PC and state this cycle (pipeline or memory stall).
Halt_req  in  1  decoded halt instruction at the current PC.
Branch_en  in  1  current instruction is a branch.
Branch_cond  in  1  branch condition evaluated true.
Jptr_in  in  3  jump pointer field of the current instruction.
Jump  in  JW  target address returned combinationally by the jump table.
Jptr  out  3  pointer to the jump table; equals Jptr_in when Branch_en=1, else 3'b000.
PC  out  PC_W  current program counter (registered).
Running  out  1  high while in RUN.
Done  out  1  high in HALT.
Err  out  1  high in ERR.
Cycles  out  CYC_W  RUN-state cycle count, stalls included.

Behaviour:
- Reset is asynchronous and active-high. It is applied immediately, regardless of Clk.
  - State goes to IDLE.
  - PC=0, Cycles=0, Running=0, Done=0, Err=0.
  - Jptr follows its combinational rule and is 0 when Branch_en=0.
- Reset asserted mid-RUN aborts execution immediately; no partial PC update occurs.
- States: IDLE, RUN, HALT, ERR. Running, Done and Err are decoded from registered state, so they are glitch-free.
- IDLE:
  - Start=1 → RUN next edge, with PC=0 and Cycles=0.
  - All other inputs are ignored.
- RUN: one decision per edge, in strict priority order.
  1. Start=1: restart. PC←0, Cycles←0, stay in RUN.
  2. Stall=1: PC holds, state holds, Cycles increments.
  3. Halt_req=1: go to HALT. PC holds at the halt instruction address. Cycles increments.
  4. Branch_en=1 and Branch_cond=1:
     - If Jptr_in ≥ NUM_TGT: go to ERR and PC holds.
     - Otherwise PC←{0, Jump}, zero-extended.
     - Cycles increments in both cases.
  5. Branch_en=1 and Branch_cond=0: PC←PC+1 (branch not taken).
  6. Otherwise:
     - PC←PC+1.
     - If PC = 2^PC_W-1, go to ERR instead and PC holds (no silent wrap to 0).
- The out-of-range pointer check uses Jptr_in. The Jump value is not used for the check, because invalid codes alias onto a legal-looking address (all-ones truncated to JW bits).
- Cycles saturates at 2^CYC_W-1 and does not wrap. It increments only on edges where the state is RUN before the edge.
- HALT and ERR:
  - PC and Cycles are frozen.
  - Start=1 → RUN with PC←0 and Cycles←0; Done/Err clear on the same edge.
  - All other inputs are ignored.
- Branch latency: the pointer is presented and the target is loaded in the same cycle. The new PC is visible one edge after the branch instruction's cycle. There is no delay slot.
- Jptr is purely combinational from Branch_en and Jptr_in. It is driven in every state, so the table can be probed while idle.

Test Plan:
- Reset then Start; 3 cycles with no control inputs → PC sequence 0,1,2,3; Running=1; Cycles=3.
- In RUN at PC=5: Branch_en=1, Branch_cond=1, Jptr_in=3, Jump=27 → PC=27 on the next edge. Repeat with Branch_cond=0 → PC=6.
- At PC=10: Stall=1 for 2 cycles together with Branch_en=1, Branch_cond=1, Jptr_in=1 → PC stays 10 and Cycles +2. Release Stall with the branch still asserted → PC=4.
- At PC=30: Halt_req=1 → Done=1, Running=0, PC=30 frozen. Then Start pulse → PC=0, Done=0, Running=1, Cycles=0.
- Faults:
  - Taken branch with Jptr_in=6 (Jump=63) → Err=1, PC unchanged.
  - Separately, sequential execution to PC=255 with PC_W=8 → Err=1 on the next edge, PC=255.
- Reset pulsed asynchronously between edges while RUN at PC=12 → outputs go to 0 before the next edge; Start is required to resume.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: owns the PC, runs/halts execution,
// resolves taken branches through the jump table and counts RUN cycles.
module pc_sequencer #(
    parameter int PC_W    = 8,
    parameter int JW      = 6,
    parameter int NUM_TGT = 5,
    parameter int CYC_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             Halt_req,
    input  logic             Branch_en,
    input  logic             Branch_cond,
    input  logic [2:0]       Jptr_in,
    input  logic [JW-1:0]    Jump,
    output logic [2:0]       Jptr,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done,
    output logic             Err,
    output logic [CYC_W-1:0] Cycles
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    localparam logic [PC_W-1:0]  PC_MAX  = {PC_W{1'b1}};
    localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [PC_W-1:0]  next_pc;
    logic [CYC_W-1:0] next_cycles;
    logic [CYC_W-1:0] cycles_inc;
    logic [PC_W-1:0]  target;
    logic             ptr_bad;

    // Invalid pointer codes alias onto legal-looking table entries, so the check uses the pointer itself.
    assign ptr_bad    = (int'(Jptr_in) >= NUM_TGT);
    assign target     = PC_W'(Jump);
    assign cycles_inc = (Cycles == CYC_MAX) ? Cycles : Cycles + 1'b1;

    assign Jptr    = Branch_en ? Jptr_in : 3'b000;
    assign Running = (state == RUN);
    assign Done    = (state == HALT);
    assign Err     = (state == ERR);

    always_comb begin
        next_state  = state;
        next_pc     = PC;
        next_cycles = Cycles;
        case (state)
            RUN: begin
                if (Start) begin
                    next_pc     = '0;
                    next_cycles = '0;
                end else begin
                    next_cycles = cycles_inc;
                    if (Stall) begin
                        next_pc = PC;
                    end else if (Halt_req) begin
                        next_state = HALT;
                    end else if (Branch_en && Branch_cond) begin
                        if (ptr_bad) begin
                            next_state = ERR;
                        end else begin
                            next_pc = target;
                        end
                    end else if (PC == PC_MAX) begin
                        // Running off the end of program memory is a fault, never a silent wrap.
                        next_state = ERR;
                    end else begin
                        next_pc = PC + 1'b1;
                    end
                end
            end
            default: begin
                if (Start) begin
                    next_state  = RUN;
                    next_pc     = '0;
                    next_cycles = '0;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            PC     <= '0;
            Cycles <= '0;
        end else begin
            state  <= next_state;
            PC     <= next_pc;
            Cycles <= next_cycles;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: sequencing, branches, stalls,
// halt/restart, both fault paths and asynchronous reset.
module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Stall;
    logic        Halt_req;
    logic        Branch_en;
    logic        Branch_cond;
    logic [2:0]  Jptr_in;
    logic [5:0]  Jump;
    logic [2:0]  Jptr;
    logic [7:0]  PC;
    logic        Running;
    logic        Done;
    logic        Err;
    logic [15:0] Cycles;

    int tests_run    = 0;
    int tests_failed = 0;

    pc_sequencer #(.PC_W(8), .JW(6), .NUM_TGT(5), .CYC_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt_req(Halt_req),
        .Branch_en(Branch_en), .Branch_cond(Branch_cond), .Jptr_in(Jptr_in), .Jump(Jump),
        .Jptr(Jptr), .PC(PC), .Running(Running), .Done(Done), .Err(Err), .Cycles(Cycles)
    );

    always #5 Clk = ~Clk;

    task automatic clear_inputs;
        Start = 0; Stall = 0; Halt_req = 0; Branch_en = 0; Branch_cond = 0;
        Jptr_in = 0; Jump = 0;
    endtask

    // Outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic pulse_start;
        Start = 1;
        tick(1);
        Start = 0;
    endtask

    task automatic branch_to(input logic [5:0] tgt);
        Branch_en = 1; Branch_cond = 1; Jptr_in = 3'd0; Jump = tgt;
        tick(1);
        Branch_en = 0; Branch_cond = 0; Jump = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        Reset = 0;
        #2 Reset = 1;
        #1;
        tests_run++; if (PC !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_pc: got %0d expected 0", PC); end
        tests_run++; if (Cycles !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_cycles: got %0d expected 0", Cycles); end
        tests_run++; if ({Running, Done, Err} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_flags: got %b expected 000", {Running, Done, Err}); end
        Jptr_in = 3'd5;
        #1;
        tests_run++; if (Jptr !== 3'd0) begin tests_failed++; $display("[TB] FAIL jptr_disabled: got %0d expected 0", Jptr); end
        Branch_en = 1;
        #1;
        tests_run++; if (Jptr !== 3'd5) begin tests_failed++; $display("[TB] FAIL jptr_probe: got %0d expected 5", Jptr); end
        clear_inputs();
        tick(2);
        Reset = 0;
        tick(1);
    endtask

    task automatic test_sequential;
        pulse_start();
        tests_run++; if (PC !== 8'd0 || Running !== 1'b1) begin tests_failed++; $display("[TB] FAIL start: got pc=%0d run=%b expected pc=0 run=1", PC, Running); end
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            tests_run++; if (PC !== 8'(i)) begin tests_failed++; $display("[TB] FAIL seq_pc: got %0d expected %0d", PC, i); end
        end
        tests_run++; if (Cycles !== 16'd3) begin tests_failed++; $display("[TB] FAIL seq_cycles: got %0d expected 3", Cycles); end
    endtask

    task automatic test_branch;
        tick(2);
        tests_run++; if (PC !== 8'd5) begin tests_failed++; $display("[TB] FAIL pre_branch_pc: got %0d expected 5", PC); end
        Branch_en = 1; Branch_cond = 1; Jptr_in = 3'd3; Jump = 6'd27;
        #1;
        tests_run++; if (Jptr !== 3'd3) begin tests_failed++; $display("[TB] FAIL branch_jptr: got %0d expected 3", Jptr); end
        tick(1);
        clear_inputs();
        tests_run++; if (PC !== 8'd27 || Cycles !== 16'd6) begin tests_failed++; $display("[TB] FAIL branch_taken: got pc=%0d cyc=%0d expected pc=27 cyc=6", PC, Cycles); end
        // Start outranks stall: restart wins.
        Start = 1; Stall = 1;
        tick(1);
        clear_inputs();
        tests_run++; if (PC !== 8'd0 || Cycles !== 16'd0 || Running !== 1'b1) begin tests_failed++; $display("[TB] FAIL restart: got pc=%0d cyc=%0d expected pc=0 cyc=0", PC, Cycles); end
        tick(5);
        Branch_en = 1; Branch_cond = 0; Jptr_in = 3'd3; Jump = 6'd27;
        tick(1);
        clear_inputs();
        tests_run++; if (PC !== 8'd6) begin tests_failed++; $display("[TB] FAIL branch_not_taken: got %0d expected 6", PC); end
        pulse_start();
        Branch_en = 1; Branch_cond = 1; Jptr_in = 3'd4; Jump = 6'd9;
        tick(1);
        clear_inputs();
        tests_run++; if (PC !== 8'd9 || Err !== 1'b0) begin tests_failed++; $display("[TB] FAIL branch_ptr4: got pc=%0d err=%b expected pc=9 err=0", PC, Err); end
    endtask

    task automatic test_stall;
        pulse_start();
        branch_to(6'd10);
        Stall = 1; Branch_en = 1; Branch_cond = 1; Jptr_in = 3'd1; Jump = 6'd4;
        tick(2);
        tests_run++; if (PC !== 8'd10 || Cycles !== 16'd3) begin tests_failed++; $display("[TB] FAIL stall_hold: got pc=%0d cyc=%0d expected pc=10 cyc=3", PC, Cycles); end
        Stall = 0;
        tick(1);
        clear_inputs();
        tests_run++; if (PC !== 8'd4 || Cycles !== 16'd4) begin tests_failed++; $display("[TB] FAIL stall_release: got pc=%0d cyc=%0d expected pc=4 cyc=4", PC, Cycles); end
    endtask

    task automatic test_halt;
        pulse_start();
        branch_to(6'd30);
        Halt_req = 1;
        tick(1);
        clear_inputs();
        tests_run++; if (Done !== 1'b1 || Running !== 1'b0 || PC !== 8'd30 || Cycles !== 16'd2) begin tests_failed++; $display("[TB] FAIL halt: got done=%b run=%b pc=%0d cyc=%0d expected 1 0 30 2", Done, Running, PC, Cycles); end
        Branch_en = 1; Branch_cond = 1; Jump = 6'd7;
        tick(3);
        clear_inputs();
        tests_run++; if (PC !== 8'd30 || Cycles !== 16'd2 || Done !== 1'b1) begin tests_failed++; $display("[TB] FAIL halt_frozen: got pc=%0d cyc=%0d done=%b expected 30 2 1", PC, Cycles, Done); end
        pulse_start();
        tests_run++; if (PC !== 8'd0 || Done !== 1'b0 || Running !== 1'b1 || Cycles !== 16'd0) begin tests_failed++; $display("[TB] FAIL halt_restart: got pc=%0d done=%b run=%b cyc=%0d expected 0 0 1 0", PC, Done, Running, Cycles); end
    endtask

    task automatic test_fault_ptr;
        pulse_start();
        branch_to(6'd7);
        Branch_en = 1; Branch_cond = 1; Jptr_in = 3'd6; Jump = 6'd63;
        tick(1);
        clear_inputs();
        tests_run++; if (Err !== 1'b1 || PC !== 8'd7 || Running !== 1'b0 || Cycles !== 16'd2) begin tests_failed++; $display("[TB] FAIL ptr6_fault: got err=%b pc=%0d run=%b cyc=%0d expected 1 7 0 2", Err, PC, Running, Cycles); end
        tick(3);
        tests_run++; if (Err !== 1'b1 || PC !== 8'd7 || Cycles !== 16'd2) begin tests_failed++; $display("[TB] FAIL err_frozen: got err=%b pc=%0d cyc=%0d expected 1 7 2", Err, PC, Cycles); end
        pulse_start();
        branch_to(6'd20);
        Branch_en = 1; Branch_cond = 1; Jptr_in = 3'd5; Jump = 6'd31;
        tick(1);
        clear_inputs();
        tests_run++; if (Err !== 1'b1 || PC !== 8'd20) begin tests_failed++; $display("[TB] FAIL ptr5_fault: got err=%b pc=%0d expected 1 20", Err, PC); end
    endtask

    task automatic test_fault_wrap;
        pulse_start();
        tests_run++; if (Err !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_clear: got %b expected 0", Err); end
        branch_to(6'd63);
        tick(191);
        tests_run++; if (PC !== 8'd254 || Err !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrap_pre: got pc=%0d err=%b expected 254 0", PC, Err); end
        tick(1);
        tests_run++; if (PC !== 8'd255 || Running !== 1'b1 || Cycles !== 16'd193) begin tests_failed++; $display("[TB] FAIL wrap_top: got pc=%0d run=%b cyc=%0d expected 255 1 193", PC, Running, Cycles); end
        tick(1);
        tests_run++; if (Err !== 1'b1 || PC !== 8'd255 || Cycles !== 16'd194) begin tests_failed++; $display("[TB] FAIL wrap_fault: got err=%b pc=%0d cyc=%0d expected 1 255 194", Err, PC, Cycles); end
    endtask

    task automatic test_async_reset;
        pulse_start();
        branch_to(6'd12);
        tests_run++; if (PC !== 8'd12 || Running !== 1'b1) begin tests_failed++; $display("[TB] FAIL pre_reset: got pc=%0d run=%b expected 12 1", PC, Running); end
        #2 Reset = 1;
        #1;
        tests_run++; if (PC !== 8'd0 || Cycles !== 16'd0 || {Running, Done, Err} !== 3'b000) begin tests_failed++; $display("[TB] FAIL async_reset: got pc=%0d cyc=%0d flags=%b expected 0 0 000", PC, Cycles, {Running, Done, Err}); end
        #2 Reset = 0;
        Branch_en = 1; Branch_cond = 1; Jump = 6'd40; Halt_req = 1;
        tick(3);
        clear_inputs();
        tests_run++; if (PC !== 8'd0 || Cycles !== 16'd0 || {Running, Done, Err} !== 3'b000) begin tests_failed++; $display("[TB] FAIL idle_ignore: got pc=%0d cyc=%0d flags=%b expected 0 0 000", PC, Cycles, {Running, Done, Err}); end
        pulse_start();
        tick(1);
        tests_run++; if (PC !== 8'd1 || Running !== 1'b1) begin tests_failed++; $display("[TB] FAIL resume: got pc=%0d run=%b expected 1 1", PC, Running); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_halt();
        test_fault_ptr();
        test_fault_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
